// File: rtl/debug_ctrl_pkg.sv
// Shared command/status codes, FSM state encoding and default sizes for the
// MIPS debug sequencer.
package debug_ctrl_pkg;

    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_DUMP  = 8'h44;
    localparam logic [7:0] CMD_FLUSH = 8'h46;

    localparam logic [7:0] STATUS_ACK = 8'h06;
    localparam logic [7:0] STATUS_NAK = 8'h15;

    localparam int DEFAULT_REGISTERS_BANK_SIZE = 32;
    localparam int DEFAULT_BUS_SIZE            = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DUMP   = 3'd4,
        ST_STATUS = 3'd5
    } state_t;

endpackage

// File: rtl/debug_ctrl_byte_serializer.sv
// Snapshot register plus byte counter that streams the captured register
// bank out LSB byte first, one byte per valid/ready handshake.
module debug_byte_serializer #(
    parameter int N_BYTES = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [N_BYTES*8-1:0]   bus_in,
    input  logic                   start,
    input  logic                   ready,
    output logic                   valid,
    output logic [7:0]             data,
    output logic                   done
);

    localparam int CW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_BYTES - 1);

    logic [N_BYTES*8-1:0] snapshot;
    logic [CW-1:0]        cnt;
    logic [CW+2:0]        bit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot <= '0;
            cnt      <= '0;
        end else if (load) begin
            snapshot <= bus_in;
            cnt      <= '0;
        end else if (valid && ready) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // start is held for the whole dump; the stream is live while it is high
    assign valid   = start;
    assign bit_idx = {cnt, 3'b000};
    assign data    = valid ? snapshot[bit_idx +: 8] : 8'h00;
    assign done    = valid && ready && (cnt == LAST);

endmodule

// File: rtl/debug_ctrl.sv
// Debug sequencer: decodes UART command bytes, gates the pipeline
// (run/step/flush) and streams register-bank dumps or status bytes to TX.
module debug_ctrl
    import debug_ctrl_pkg::*;
#(
    parameter int REGISTERS_BANK_SIZE = DEFAULT_REGISTERS_BANK_SIZE,
    parameter int BUS_SIZE            = DEFAULT_BUS_SIZE
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_cmd_valid,
    input  logic [7:0]                            i_cmd_data,
    output logic                                  o_cmd_ready,
    input  logic                                  i_end_program,
    input  logic [REGISTERS_BANK_SIZE*BUS_SIZE-1:0] i_regs_bus,
    output logic                                  o_tx_valid,
    output logic [7:0]                            o_tx_data,
    input  logic                                  i_tx_ready,
    output logic                                  o_pipeline_enable,
    output logic                                  o_flush,
    output logic                                  o_busy
);

    localparam int N_BYTES = REGISTERS_BANK_SIZE * BUS_SIZE / 8;

    state_t     state;
    logic [7:0] status_byte;
    logic       ser_load;
    logic       ser_valid;
    logic [7:0] ser_data;
    logic       ser_done;

    assign ser_load = (state == ST_IDLE) && i_cmd_valid && (i_cmd_data == CMD_DUMP);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            status_byte <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: if (i_cmd_valid) begin
                    case (i_cmd_data)
                        CMD_RUN:   state <= ST_RUN;
                        CMD_STEP:  state <= ST_STEP;
                        CMD_FLUSH: state <= ST_FLUSH;
                        CMD_DUMP:  state <= ST_DUMP;
                        default: begin
                            state       <= ST_STATUS;
                            status_byte <= STATUS_NAK;
                        end
                    endcase
                end
                ST_RUN: if (i_end_program) begin
                    state       <= ST_STATUS;
                    status_byte <= STATUS_ACK;
                end
                // a step requested on a halted pipeline is refused
                ST_STEP: begin
                    state       <= ST_STATUS;
                    status_byte <= i_end_program ? STATUS_NAK : STATUS_ACK;
                end
                ST_FLUSH: begin
                    state       <= ST_STATUS;
                    status_byte <= STATUS_ACK;
                end
                ST_DUMP:   if (ser_done)   state <= ST_IDLE;
                ST_STATUS: if (i_tx_ready) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    debug_byte_serializer #(
        .N_BYTES (N_BYTES)
    ) u_ser (
        .clk    (i_clk),
        .rst    (i_reset),
        .load   (ser_load),
        .bus_in (i_regs_bus),
        .start  (state == ST_DUMP),
        .ready  (i_tx_ready),
        .valid  (ser_valid),
        .data   (ser_data),
        .done   (ser_done)
    );

    assign o_cmd_ready       = (state == ST_IDLE);
    assign o_busy            = (state != ST_IDLE);
    assign o_pipeline_enable = ((state == ST_RUN) || (state == ST_STEP)) && !i_end_program;
    assign o_flush           = (state == ST_FLUSH);
    assign o_tx_valid        = (state == ST_STATUS) || ser_valid;
    assign o_tx_data         = (state == ST_STATUS) ? status_byte : ser_data;

endmodule
